// File: rtl/csr_unit_if.sv
// csr_unit_if: CSR access bus between the execute stage and csr_unit.
interface csr_unit_if #(
    parameter int NUM_CUSTOM = 4
);
    logic [2:0]                 f3;
    logic [31:0]                write_data;
    logic                       write_enable;
    logic                       src_is_zero;
    logic [11:0]                address;
    logic                       instr_retired;
    logic                       flush_done;
    logic [31:0]                read_data;
    logic                       illegal;
    logic                       flush_cache_flag;
    logic [32*NUM_CUSTOM-1:0]   custom_csrs;

    modport master (
        output f3, write_data, write_enable, src_is_zero, address, instr_retired, flush_done,
        input  read_data, illegal, flush_cache_flag, custom_csrs
    );

    modport slave (
        input  f3, write_data, write_enable, src_is_zero, address, instr_retired, flush_done,
        output read_data, illegal, flush_cache_flag, custom_csrs
    );
endinterface

// File: rtl/csr_unit.sv
// csr_unit: Zicsr/Zicntr CSR bank with custom CSRs, cycle/instret counters and cache-flush request.
module csr_unit #(
    parameter int NUM_CUSTOM    = 4,
    parameter int COUNTER_WIDTH = 64
) (
    input logic       clk,
    input logic       rst,
    csr_unit_if.slave bus
);
    localparam int HW = COUNTER_WIDTH - 32;
    localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

    typedef enum logic {IDLE = 1'b0, FLUSHING = 1'b1} flush_state_e;

    logic [NUM_CUSTOM-1:0][31:0] custom_q, custom_d;
    logic [COUNTER_WIDTH-1:0]    mcycle_q, mcycle_d, minstret_q, minstret_d;
    flush_state_e                flush_state;
    logic [31:0]                 old_val, new_val, cyc_hi, ret_hi;
    logic                        is_custom, is_counter, is_ro, mapped, would_write, eff_write;
    logic                        wr_cyc_lo, wr_cyc_hi, wr_ret_lo, wr_ret_hi;

    assign cyc_hi    = 32'(mcycle_q >> 32);
    assign ret_hi    = 32'(minstret_q >> 32);
    assign is_custom = bus.address[11:4] == 8'h7C && {1'b0, bus.address[3:0]} < 5'(NUM_CUSTOM);

    // Address decode and combinational read of the pre-edge CSR value
    always_comb begin
        old_val    = '0;
        is_counter = 1'b1;
        is_ro      = 1'b0;
        case (bus.address)
            12'hB00: old_val = mcycle_q[31:0];
            12'hB80: old_val = cyc_hi;
            12'hB02: old_val = minstret_q[31:0];
            12'hB82: old_val = ret_hi;
            12'hC00: begin old_val = mcycle_q[31:0];   is_ro = 1'b1; end
            12'hC80: begin old_val = cyc_hi;           is_ro = 1'b1; end
            12'hC02: begin old_val = minstret_q[31:0]; is_ro = 1'b1; end
            12'hC82: begin old_val = ret_hi;           is_ro = 1'b1; end
            default: is_counter = 1'b0;
        endcase
        for (int i = 0; i < NUM_CUSTOM; i++)
            if (is_custom && bus.address[3:0] == 4'(i)) old_val = custom_q[i];
    end

    // Set/clear with a zero source is a pure read, so it never counts as a write
    assign mapped      = is_custom | is_counter;
    assign would_write = bus.write_enable && bus.f3[1:0] != 2'b00 && !(bus.f3[1] && bus.src_is_zero);
    assign eff_write   = would_write && mapped && !is_ro;
    assign new_val     = bus.f3[1:0] == 2'b01 ? bus.write_data :
                         bus.f3[1:0] == 2'b10 ? old_val | bus.write_data :
                                                old_val & ~bus.write_data;

    assign wr_cyc_lo = eff_write && bus.address == 12'hB00;
    assign wr_cyc_hi = eff_write && bus.address == 12'hB80;
    assign wr_ret_lo = eff_write && bus.address == 12'hB02;
    assign wr_ret_hi = eff_write && bus.address == 12'hB82;

    // Counter next state: a software write to a half replaces the increment and freezes the other half
    always_comb begin
        mcycle_d   = wr_cyc_lo ? {mcycle_q[COUNTER_WIDTH-1:32], new_val} :
                     wr_cyc_hi ? {new_val[HW-1:0], mcycle_q[31:0]} :
                                 mcycle_q + ONE;
        minstret_d = wr_ret_lo ? {minstret_q[COUNTER_WIDTH-1:32], new_val} :
                     wr_ret_hi ? {new_val[HW-1:0], minstret_q[31:0]} :
                     bus.instr_retired ? minstret_q + ONE : minstret_q;
    end

    // The flush FSM state lives in custom CSR 0 bit 0
    assign flush_state = flush_state_e'(custom_q[0][0]);

    // Custom CSR next state: hardware clears the flush bit on done, software writes take priority
    always_comb begin
        custom_d = custom_q;
        if (flush_state == FLUSHING && bus.flush_done) custom_d[0][0] = 1'b0;
        for (int i = 0; i < NUM_CUSTOM; i++)
            if (eff_write && is_custom && bus.address[3:0] == 4'(i)) custom_d[i] = new_val;
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            custom_q   <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            custom_q   <= custom_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign bus.read_data        = old_val;
    assign bus.illegal          = bus.write_enable && (!mapped || (is_ro && would_write));
    assign bus.flush_cache_flag = flush_state == FLUSHING;
    assign bus.custom_csrs      = custom_q;
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed vector table plus randomized run against a reference CSR model, on two configurations.
module tb_csr_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csr_unit_if #(.NUM_CUSTOM(4)) bus0();
    csr_unit_if #(.NUM_CUSTOM(2)) bus1();

    csr_unit #(.NUM_CUSTOM(4), .COUNTER_WIDTH(64)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    csr_unit #(.NUM_CUSTOM(2), .COUNTER_WIDTH(40)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int checks = 0;
    int errors = 0;

    logic [31:0] cust [2][16];
    logic [63:0] cyc [2];
    logic [63:0] ret [2];
    int          nc [2] = '{4, 2};
    int          cw [2] = '{64, 40};

    logic        s_we, s_sz, s_ir, s_fd;
    logic [2:0]  s_f3;
    logic [11:0] s_a;
    logic [31:0] s_wd;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [11:0] a;
        logic [31:0] wd;
        logic        sz, ir, fd;
        logic        chk_rd;
        logic [31:0] rd;
        logic        ill;
        logic        flag;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic logic [63:0] msk(int d);
        return cw[d] == 64 ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << cw[d]) - 64'd1;
    endfunction

    function automatic bit m_custom(int d, logic [11:0] a);
        return int'(a) >= 'h7C0 && int'(a) < 'h7C0 + nc[d];
    endfunction

    function automatic bit m_ro(logic [11:0] a);
        return a inside {12'hC00, 12'hC80, 12'hC02, 12'hC82};
    endfunction

    function automatic bit m_mapped(int d, logic [11:0] a);
        return m_custom(d, a) || m_ro(a) || (a inside {12'hB00, 12'hB80, 12'hB02, 12'hB82});
    endfunction

    function automatic logic [31:0] m_read(int d, logic [11:0] a);
        if (m_custom(d, a)) return cust[d][int'(a) - 'h7C0];
        case (a)
            12'hB00, 12'hC00: return cyc[d][31:0];
            12'hB80, 12'hC80: return cyc[d][63:32];
            12'hB02, 12'hC02: return ret[d][31:0];
            12'hB82, 12'hC82: return ret[d][63:32];
            default:          return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_new(logic [31:0] old, logic [2:0] f3, logic [31:0] wd);
        case (f3[1:0])
            2'b01:   return wd;
            2'b10:   return old | wd;
            default: return old & ~wd;
        endcase
    endfunction

    function automatic bit m_would();
        return s_we && s_f3[1:0] != 2'b00 && !(s_f3[1] && s_sz);
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            cyc[d] = 64'd0;
            ret[d] = 64'd0;
            for (int i = 0; i < 16; i++) cust[d][i] = 32'd0;
        end
    endtask

    task automatic apply(input logic we, input logic [2:0] f3, input logic [11:0] a,
                         input logic [31:0] wd, input logic sz, input logic ir, input logic fd);
        s_we = we; s_f3 = f3; s_a = a; s_wd = wd; s_sz = sz; s_ir = ir; s_fd = fd;
        bus0.write_enable = we; bus0.f3 = f3; bus0.address = a; bus0.write_data = wd;
        bus0.src_is_zero = sz; bus0.instr_retired = ir; bus0.flush_done = fd;
        bus1.write_enable = we; bus1.f3 = f3; bus1.address = a; bus1.write_data = wd;
        bus1.src_is_zero = sz; bus1.instr_retired = ir; bus1.flush_done = fd;
        #2;
    endtask

    task automatic check_model();
        for (int d = 0; d < 2; d++) begin
            logic [127:0] e;
            logic         exp_ill;
            exp_ill = s_we && (!m_mapped(d, s_a) || (m_ro(s_a) && m_would()));
            e = '0;
            for (int i = 0; i < nc[d]; i++) e[32*i +: 32] = cust[d][i];
            chk($sformatf("rd%0d@%h", d, s_a), d == 0 ? bus0.read_data : bus1.read_data, m_read(d, s_a));
            chk($sformatf("ill%0d@%h", d, s_a), d == 0 ? bus0.illegal : bus1.illegal, exp_ill);
            chk($sformatf("flag%0d", d), d == 0 ? bus0.flush_cache_flag : bus1.flush_cache_flag, cust[d][0][0]);
            chk($sformatf("custom%0d", d), d == 0 ? bus0.custom_csrs : {64'd0, bus1.custom_csrs}, e);
        end
    endtask

    task automatic advance();
        logic [31:0] ncst [2][16];
        logic [63:0] ncy [2];
        logic [63:0] nrt [2];
        for (int d = 0; d < 2; d++) begin
            logic [31:0] nv;
            bit          eff;
            nv  = m_new(m_read(d, s_a), s_f3, s_wd);
            eff = m_would() && m_mapped(d, s_a) && !m_ro(s_a);
            ncy[d] = (cyc[d] + 64'd1) & msk(d);
            nrt[d] = (ret[d] + (s_ir ? 64'd1 : 64'd0)) & msk(d);
            for (int i = 0; i < 16; i++) ncst[d][i] = cust[d][i];
            if (cust[d][0][0] && s_fd) ncst[d][0][0] = 1'b0;
            if (eff) begin
                if (m_custom(d, s_a)) ncst[d][int'(s_a) - 'h7C0] = nv;
                case (s_a)
                    12'hB00: ncy[d] = {cyc[d][63:32], nv};
                    12'hB80: ncy[d] = {nv, cyc[d][31:0]} & msk(d);
                    12'hB02: nrt[d] = {ret[d][63:32], nv};
                    12'hB82: nrt[d] = {nv, ret[d][31:0]} & msk(d);
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            cyc[d] = ncy[d];
            ret[d] = nrt[d];
            for (int i = 0; i < 16; i++) cust[d][i] = ncst[d][i];
        end
        #1;
    endtask

    function automatic vec_t mk(logic we, logic [2:0] f3, logic [11:0] a, logic [31:0] wd,
                                logic sz, logic ir, logic fd, logic chk_rd, logic [31:0] rd,
                                logic ill, logic flag);
        vec_t v;
        v.we = we; v.f3 = f3; v.a = a; v.wd = wd; v.sz = sz; v.ir = ir; v.fd = fd;
        v.chk_rd = chk_rd; v.rd = rd; v.ill = ill; v.flag = flag;
        return v;
    endfunction

    logic [11:0] addrs [14] = '{12'h7C0, 12'h7C1, 12'h7C2, 12'h7C3, 12'h7C4, 12'hB00, 12'hB80,
                                12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h123};

    initial begin
        m_reset();
        bus0.write_enable = 0; bus0.f3 = 0; bus0.address = 0; bus0.write_data = 0;
        bus0.src_is_zero = 0; bus0.instr_retired = 0; bus0.flush_done = 0;
        bus1.write_enable = 0; bus1.f3 = 0; bus1.address = 0; bus1.write_data = 0;
        bus1.src_is_zero = 0; bus1.instr_retired = 0; bus1.flush_done = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 3'b000, 12'hC00, 0, 0, 0, 0, 1, 32'(i), 0, 0));
        tbl.push_back(mk(0, 3'b000, 12'hC80, 0,            0, 0, 0, 1, 32'h0,        0, 0));
        tbl.push_back(mk(1, 3'b001, 12'h7C1, 32'hA5A50000, 0, 0, 0, 1, 32'h0,        0, 0));
        tbl.push_back(mk(1, 3'b010, 12'h7C1, 32'h000000FF, 0, 0, 0, 1, 32'hA5A50000, 0, 0));
        tbl.push_back(mk(1, 3'b011, 12'h7C1, 32'hA000000F, 0, 0, 0, 1, 32'hA5A500FF, 0, 0));
        tbl.push_back(mk(1, 3'b010, 12'h7C1, 32'h0000FFFF, 1, 0, 0, 1, 32'h05A500F0, 0, 0));
        tbl.push_back(mk(0, 3'b000, 12'h7C1, 0,            0, 0, 0, 1, 32'h05A500F0, 0, 0));
        tbl.push_back(mk(1, 3'b001, 12'h7C0, 32'h3,        0, 0, 0, 1, 32'h0,        0, 0));
        tbl.push_back(mk(0, 3'b000, 12'h7C0, 0,            0, 0, 1, 1, 32'h3,        0, 1));
        tbl.push_back(mk(0, 3'b000, 12'h7C0, 0,            0, 0, 0, 1, 32'h2,        0, 0));
        tbl.push_back(mk(1, 3'b001, 12'h7C0, 32'h1,        0, 0, 0, 1, 32'h2,        0, 0));
        tbl.push_back(mk(1, 3'b001, 12'h7C0, 32'h5,        0, 0, 1, 1, 32'h1,        0, 1));
        tbl.push_back(mk(0, 3'b000, 12'h7C0, 0,            0, 0, 1, 1, 32'h5,        0, 1));
        tbl.push_back(mk(0, 3'b000, 12'h7C0, 0,            0, 0, 1, 1, 32'h4,        0, 0));
        tbl.push_back(mk(0, 3'b000, 12'h7C0, 0,            0, 0, 0, 1, 32'h4,        0, 0));
        tbl.push_back(mk(1, 3'b001, 12'hB80, 32'h0,        0, 0, 0, 1, 32'h0,        0, 0));
        tbl.push_back(mk(1, 3'b001, 12'hB00, 32'hFFFFFFFF, 0, 0, 0, 0, 32'h0,        0, 0));
        tbl.push_back(mk(0, 3'b000, 12'hB00, 0,            0, 0, 0, 1, 32'hFFFFFFFF, 0, 0));
        tbl.push_back(mk(0, 3'b000, 12'hB00, 0,            0, 0, 0, 1, 32'h0,        0, 0));
        tbl.push_back(mk(0, 3'b000, 12'hB80, 0,            0, 0, 0, 1, 32'h1,        0, 0));
        tbl.push_back(mk(1, 3'b001, 12'hB80, 32'hFFFFFFFF, 0, 0, 0, 1, 32'h1,        0, 0));
        tbl.push_back(mk(0, 3'b000, 12'hB80, 0,            0, 0, 0, 1, 32'hFFFFFFFF, 0, 0));
        tbl.push_back(mk(1, 3'b001, 12'hC00, 32'h1234,     0, 0, 0, 0, 32'h0,        1, 0));
        tbl.push_back(mk(1, 3'b001, 12'h123, 32'h5,        0, 0, 0, 1, 32'h0,        1, 0));
        tbl.push_back(mk(1, 3'b010, 12'hC02, 32'h0,        1, 0, 0, 0, 32'h0,        0, 0));
        tbl.push_back(mk(1, 3'b001, 12'hB02, 32'h0,        0, 0, 0, 1, 32'h0,        0, 0));
        tbl.push_back(mk(0, 3'b000, 12'hB02, 0,            0, 1, 0, 1, 32'h0,        0, 0));
        tbl.push_back(mk(1, 3'b001, 12'hB02, 32'h10,       0, 1, 0, 1, 32'h1,        0, 0));
        tbl.push_back(mk(0, 3'b000, 12'hB02, 0,            0, 1, 0, 1, 32'h10,       0, 0));
        tbl.push_back(mk(0, 3'b000, 12'hB02, 0,            0, 0, 0, 1, 32'h11,       0, 0));

        foreach (tbl[i]) begin
            apply(tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].sz, tbl[i].ir, tbl[i].fd);
            if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rd", i), bus0.read_data, tbl[i].rd);
            chk($sformatf("tbl%0d_ill", i), bus0.illegal, tbl[i].ill);
            chk($sformatf("tbl%0d_flag", i), bus0.flush_cache_flag, tbl[i].flag);
            check_model();
            advance();
        end

        apply(1, 3'b001, 12'hB80, 32'hFFFFFFFF, 0, 0, 0);
        check_model();
        advance();
        apply(0, 3'b000, 12'hB80, 0, 0, 0, 0);
        chk("cw40_hi", bus1.read_data, 32'hFF);
        check_model();
        advance();

        for (int n = 0; n < 400; n++) begin
            int k;
            k = int'($urandom_range(0, 14));
            apply($urandom_range(0, 3) != 0, 3'($urandom),
                  k == 14 ? 12'($urandom) : addrs[k], $urandom,
                  $urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 3) == 0);
            check_model();
            advance();
        end

        apply(1, 3'b001, 12'h7C0, 32'h1, 0, 0, 0);
        check_model();
        advance();
        apply(0, 3'b000, 12'h7C0, 0, 0, 0, 0);
        chk("flag_before_rst", bus0.flush_cache_flag, 1'b1);
        rst = 1'b1;
        #1;
        chk("flag_async_rst0", bus0.flush_cache_flag, 1'b0);
        chk("flag_async_rst1", bus1.flush_cache_flag, 1'b0);
        chk("custom_async_rst", bus0.custom_csrs, 128'd0);
        m_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            apply(0, 3'b000, 12'hC00, 0, 0, 0, 0);
            chk($sformatf("post_rst_cyc%0d", n), bus0.read_data, 32'(n));
            check_model();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/csr_unit.md
# csr_unit

Parametrised Zicsr/Zicntr control-status register unit for the HOLY CORE. It holds a configurable bank of custom machine CSRs starting at 0x7C0, free-running cycle and retired-instruction counters, and a self-clearing cache-flush request with a done handshake. It sits beside the register file in the execute stage. Reads are combinational; writes commit on the clock edge.

## Interface
Parameters:
- NUM_CUSTOM, 4: number of custom 32-bit R/W CSRs at 0x7C0..0x7C0+NUM_CUSTOM-1 (legal range 1..16); index 0 is the flush CSR.
- COUNTER_WIDTH, 64: width of the cycle and instret counters (legal range 33..64).

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- f3  in  3  CSR funct3: 001/101 write, 010/110 set, 011/111 clear.
- write_data  in  32  rs1 value or zero-extended uimm.
- write_enable  in  1  a CSR instruction is executing this cycle.
- src_is_zero  in  1  rs1 is x0 or uimm is 0; suppresses set/clear writes.
- address  in  12  CSR address.
- instr_retired  in  1  one instruction retires this cycle.
- flush_done  in  1  the cache has completed the requested flush.
- read_data  out  32  current value of the addressed CSR (combinational).
- illegal  out  1  the access is illegal (combinational).
- flush_cache_flag  out  1  flush request to the cache; equals custom CSR 0 bit 0.
- custom_csrs  out  32*NUM_CUSTOM  packed custom CSR values; CSR i occupies bits [32i+31:32i].

## Operation
Address map:
- 0x7C0+i: custom CSR i, R/W.
- 0xB00/0xB80: mcycle, low/high halves, R/W.
- 0xB02/0xB82: minstret, low/high halves, R/W.
- 0xC00/0xC80: cycle/cycleh, read-only aliases of mcycle.
- 0xC02/0xC82: instret/instreth, read-only aliases of minstret.
- Any other address reads 0.

Next-value computation, based on the old value `old` of the addressed CSR:
- 001/101: write_data.
- 010/110: old | write_data.
- 011/111: old & ~write_data.
- 000/100: no write.

Write commit rules:
- An effective write occurs when write_enable=1, f3 is a write/set/clear code, the address is writable, and not (set/clear with src_is_zero=1).
- illegal=1 when write_enable=1 and either the address is unmapped, or the address is in the read-only 0xCxx range and an effective write would otherwise occur. An illegal access commits nothing.

Counters:
- mcycle increments by 1 every cycle while out of reset.
- minstret increments by 1 on each cycle with instr_retired=1.
- Counters wrap modulo 2^COUNTER_WIDTH.
- High-half reads return the bits above bit 31, zero-extended. High-half writes keep only COUNTER_WIDTH-32 bits.
- A software write to either half takes priority over the increment in the same cycle. The written value is stored as-is, without +1, and the other half is unchanged.

Flush FSM:
- States are derived from custom CSR 0 bit 0: IDLE (bit=0) and FLUSHING (bit=1).
- IDLE to FLUSHING: an effective write sets bit 0.
- FLUSHING to IDLE: flush_done=1, at which point hardware clears bit 0 only. Bits 31:1 are untouched.
- A software write to 0x7C0 in the same cycle as flush_done takes priority over the hardware clear.
- flush_done while in IDLE is ignored.

## Timing
- Reset: all CSRs and counters are 0, and flush_cache_flag=0. Asserting rst mid-flush drops flush_cache_flag immediately (asynchronous reset).
- read_data and illegal settle within the same cycle as address, write_enable, f3 and src_is_zero. read_data shows the pre-edge value.
- A write is visible on read_data, custom_csrs and flush_cache_flag one cycle after the commit edge.
- mcycle read in the cycle following reset release = 0. Each following cycle reads +1.
- flush_cache_flag rises one cycle after the write and falls one cycle after flush_done is sampled high.

## Test plan
- Reset, then hold write_enable=0 for 5 cycles. Required: 0xC00 reads 0,1,2,3,4 on successive cycles; 0xC80 reads 0; all custom_csrs are 0.
- Write 0xA5A5_0000 to 0x7C1 with f3=001. Then set 0x0000_00FF with f3=010. Then clear 0xA000_000F with f3=011. Required: reads return 0xA5A5_0000, then 0xA5A5_00FF, then 0x05A5_00F0. A set with src_is_zero=1 leaves the value unchanged and raises no illegal.
- Write 0x0000_0003 to 0x7C0. Required: flush_cache_flag=1 on the next cycle. Assert flush_done for one cycle; required: flag=0 one cycle later and 0x7C0 reads 0x0000_0002. A write to 0x7C0 in the same cycle as flush_done must win.
- Write 0xFFFF_FFFF to 0xB00 with 0xB80=0. Required: after 1 cycle 0xB00=0xFFFF_FFFF, after 2 cycles 0xB80=1 and 0xB00=0. Repeat with COUNTER_WIDTH=40 and a high-half write of 0xFFFF_FFFF; required: 0xB80 reads 0xFF.
- Write to 0xC00 with f3=001. Required: illegal=1 and the counter is unchanged. Write to 0x123: illegal=1 and the read returns 0. Read 0xC02 with f3=010 and src_is_zero=1: illegal=0.
- Pulse instr_retired for 3 cycles while writing 0x10 to 0xB02 on the second pulse. Required: minstret reads 1, then 0x10, then 0x11.
